// File: rtl/compare_limiter_sequencer_pkg.sv
// Shared global parameters for the compare/limiter sequencer.
//   SINGLE          : IEEE-754 single-precision operand width.
//   TIMEOUT_DEFAULT : default number of wait cycles before a comparator abort.
package compare_limiter_sequencer_pkg;

  localparam int unsigned SINGLE          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/compare_limiter_sequencer.sv
// Clamps a float operand between an upper and a lower limit by driving an
// external float comparator twice (upper check first, then lower check).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   sta                 : one-cycle request; value/upper/lower sampled with it
//   value, upper, lower : operand and limits (IEEE-754)
//   cmp_sta             : start pulse to the comparator
//   cmp_in_1, cmp_in_2  : comparator operands A, B
//   cmp_agb, cmp_alb    : comparator A>B, A<B flags (valid with cmp_done)
//   cmp_done            : comparator completion pulse
//   limit_out           : clamped result, held until the next completion
//   hi_flag, lo_flag    : result clamped to upper / lower
//   done_sig            : one-cycle completion pulse
//   err                 : one-cycle comparator-timeout pulse
module compare_limiter_sequencer
  import compare_limiter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = SINGLE,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sta,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] upper,
  input  logic [WIDTH-1:0] lower,
  output logic             cmp_sta,
  output logic [WIDTH-1:0] cmp_in_1,
  output logic [WIDTH-1:0] cmp_in_2,
  input  logic             cmp_agb,
  input  logic             cmp_alb,
  input  logic             cmp_done,
  output logic [WIDTH-1:0] limit_out,
  output logic             hi_flag,
  output logic             lo_flag,
  output logic             done_sig,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_UP,
    S_WAIT_UP,
    S_REQ_LO,
    S_WAIT_LO,
    S_DONE
  } state_e;

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   value_q,    value_d;
  logic [WIDTH-1:0]   upper_q,    upper_d;
  logic [WIDTH-1:0]   lower_q,    lower_d;
  logic               cmp_sta_q,  cmp_sta_d;
  logic [WIDTH-1:0]   cmp_in_1_q, cmp_in_1_d;
  logic [WIDTH-1:0]   cmp_in_2_q, cmp_in_2_d;
  logic [WIDTH-1:0]   limit_q,    limit_d;
  logic               hi_q,       hi_d;
  logic               lo_q,       lo_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;

  logic               timeout_c;

  // Last allowed wait cycle without a comparator response.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      value_q    <= '0;
      upper_q    <= '0;
      lower_q    <= '0;
      cmp_sta_q  <= 1'b0;
      cmp_in_1_q <= '0;
      cmp_in_2_q <= '0;
      limit_q    <= '0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      upper_q    <= upper_d;
      lower_q    <= lower_d;
      cmp_sta_q  <= cmp_sta_d;
      cmp_in_1_q <= cmp_in_1_d;
      cmp_in_2_q <= cmp_in_2_d;
      limit_q    <= limit_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; registered outputs are computed for the state being
  // entered so they line up with that state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    value_d    = value_q;
    upper_d    = upper_q;
    lower_d    = lower_q;
    cmp_sta_d  = 1'b0;
    cmp_in_1_d = cmp_in_1_q;
    cmp_in_2_d = cmp_in_2_q;
    limit_d    = limit_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sta) begin
          value_d    = value;
          upper_d    = upper;
          lower_d    = lower;
          cmp_sta_d  = 1'b1;
          cmp_in_1_d = value;
          cmp_in_2_d = upper;
          state_d    = S_REQ_UP;
        end
      end
      S_REQ_UP: begin
        cnt_d   = '0;
        state_d = S_WAIT_UP;
      end
      S_WAIT_UP: begin
        if (cmp_done) begin
          if (cmp_agb) begin
            limit_d = upper_q;
            hi_d    = 1'b1;
            lo_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cmp_sta_d  = 1'b1;
            cmp_in_1_d = value_q;
            cmp_in_2_d = lower_q;
            state_d    = S_REQ_LO;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ_LO: begin
        cnt_d   = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (cmp_done) begin
          // Equality and NaN both leave alb low, giving a pass-through.
          limit_d = cmp_alb ? lower_q : value_q;
          hi_d    = 1'b0;
          lo_d    = cmp_alb;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmp_sta   = cmp_sta_q;
  assign cmp_in_1  = cmp_in_1_q;
  assign cmp_in_2  = cmp_in_2_q;
  assign limit_out = limit_q;
  assign hi_flag   = hi_q;
  assign lo_flag   = lo_q;
  assign done_sig  = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_compare_limiter_sequencer.sv
// Directed self-checking bench for compare_limiter_sequencer. The bench acts
// as a 1-cycle comparator whose flags are supplied per vector.
module tb_compare_limiter_sequencer;

  localparam logic [31:0] F_P5  = 32'h40A00000;
  localparam logic [31:0] F_N5  = 32'hC0A00000;
  localparam logic [31:0] F_P3  = 32'h40400000;
  localparam logic [31:0] F_N3  = 32'hC0400000;
  localparam logic [31:0] F_P1  = 32'h3F800000;
  localparam logic [31:0] F_N1  = 32'hBF800000;
  localparam logic [31:0] F_NAN = 32'h7FC00000;
  localparam logic [31:0] F_P10 = 32'h41200000;
  localparam logic [31:0] F_P8  = 32'h41000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sta = 1'b0;
  logic [31:0] value = '0;
  logic [31:0] upper = '0;
  logic [31:0] lower = '0;
  logic        cmp_sta;
  logic [31:0] cmp_in_1;
  logic [31:0] cmp_in_2;
  logic        cmp_agb = 1'b0;
  logic        cmp_alb = 1'b0;
  logic        cmp_done = 1'b0;
  logic [31:0] limit_out;
  logic        hi_flag;
  logic        lo_flag;
  logic        done_sig;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  compare_limiter_sequencer #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .sta       (sta),
    .value     (value),
    .upper     (upper),
    .lower     (lower),
    .cmp_sta   (cmp_sta),
    .cmp_in_1  (cmp_in_1),
    .cmp_in_2  (cmp_in_2),
    .cmp_agb   (cmp_agb),
    .cmp_alb   (cmp_alb),
    .cmp_done  (cmp_done),
    .limit_out (limit_out),
    .hi_flag   (hi_flag),
    .lo_flag   (lo_flag),
    .done_sig  (done_sig),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request with a 1-cycle comparator; first compare uses up_* flags,
  // second uses lo_*. Latency counted in cycles from the sta cycle.
  task automatic run_txn(input string tag, input logic [31:0] v, input logic [31:0] u,
                         input logic [31:0] l, input logic up_agb, input logic up_alb,
                         input logic lo_agb, input logic lo_alb, input logic [31:0] exp_lim,
                         input logic exp_hi, input logic exp_lo, input int exp_lat,
                         input int exp_nsta);
    int cyc  = 0;
    int nsta = 0;
    bit pend = 1'b0;
    bit seen = 1'b0;
    value = v; upper = u; lower = l; sta = 1'b1;
    while (!seen && cyc < 40) begin
      step();
      cyc++;
      sta      = 1'b0;
      cmp_done = pend;
      cmp_agb  = pend && ((nsta == 1) ? up_agb : lo_agb);
      cmp_alb  = pend && ((nsta == 1) ? up_alb : lo_alb);
      pend     = 1'b0;
      if (cmp_sta) begin
        nsta++;
        pend = 1'b1;
        check({tag, "_in1"}, cmp_in_1, v);
        check({tag, "_in2"}, cmp_in_2, (nsta == 1) ? u : l);
      end
      if (done_sig) seen = 1'b1;
    end
    check({tag, "_lat"},  32'(cyc), 32'(exp_lat));
    check({tag, "_nsta"}, 32'(nsta), 32'(exp_nsta));
    check({tag, "_lim"},  limit_out, exp_lim);
    check({tag, "_hi"},   32'(hi_flag), 32'(exp_hi));
    check({tag, "_lo"},   32'(lo_flag), 32'(exp_lo));
    step();
    cmp_done = 1'b0; cmp_agb = 1'b0; cmp_alb = 1'b0;
    check({tag, "_pulse"}, 32'(done_sig), 32'd0);
    step();
    check({tag, "_hold"}, limit_out, exp_lim);
  endtask

  initial begin
    // Reset with a coincident sta; the request must not be accepted.
    rst = 1'b1; sta = 1'b1; value = F_P5; upper = F_P3; lower = F_N3;
    step(); step();
    check("rst_lim",  limit_out, 32'd0);
    check("rst_in1",  cmp_in_1, 32'd0);
    check("rst_in2",  cmp_in_2, 32'd0);
    check("rst_sta",  32'(cmp_sta), 32'd0);
    check("rst_flag", 32'({hi_flag, lo_flag, done_sig, err}), 32'd0);
    rst = 1'b0; sta = 1'b0;
    step(); step();
    check("rst_sta_ign", 32'(cmp_sta), 32'd0);

    run_txn("up_clamp", F_P5,  F_P3, F_N3, 1'b1, 1'b0, 1'b0, 1'b0, F_P3,  1'b1, 1'b0, 3, 1);
    run_txn("lo_clamp", F_N5,  F_P3, F_N3, 1'b0, 1'b1, 1'b0, 1'b1, F_N3,  1'b0, 1'b1, 5, 2);
    run_txn("equal",    F_P1,  F_P1, F_N1, 1'b0, 1'b0, 1'b1, 1'b0, F_P1,  1'b0, 1'b0, 5, 2);
    run_txn("misconf",  F_P5,  F_N3, F_P3, 1'b1, 1'b0, 1'b0, 1'b0, F_N3,  1'b1, 1'b0, 3, 1);
    run_txn("nan",      F_NAN, F_P3, F_N3, 1'b0, 1'b0, 1'b0, 1'b0, F_NAN, 1'b0, 1'b0, 5, 2);

    // Stray cmp_done while idle is ignored.
    cmp_done = 1'b1; cmp_agb = 1'b1;
    step();
    cmp_done = 1'b0; cmp_agb = 1'b0;
    step();
    check("stray_done", 32'(done_sig), 32'd0);
    check("stray_sta",  32'(cmp_sta), 32'd0);
    check("stray_lim",  limit_out, F_NAN);

    // Comparator never answers: err after 15 wait cycles, outputs unchanged.
    begin
      int cyc = 0; int nsta = 0; int ecyc = 0; bit gd = 1'b0;
      value = F_P5; upper = F_P3; lower = F_N3; sta = 1'b1;
      while (ecyc == 0 && cyc < 40) begin
        step();
        cyc++;
        sta = 1'b0;
        if (cmp_sta) nsta++;
        if (done_sig) gd = 1'b1;
        if (err) ecyc = cyc;
      end
      check("to_errcyc", 32'(ecyc), 32'd17);
      check("to_nsta",   32'(nsta), 32'd1);
      check("to_nodone", 32'(gd), 32'd0);
      check("to_lim",    limit_out, F_NAN);
      check("to_flags",  32'({hi_flag, lo_flag}), 32'd0);
      step();
      check("to_pulse",  32'(err), 32'd0);
    end
    run_txn("after_to", F_P5, F_P3, F_N3, 1'b1, 1'b0, 1'b0, 1'b0, F_P3, 1'b1, 1'b0, 3, 1);

    // Reset while in WAIT_LO.
    value = F_N5; upper = F_P3; lower = F_N3; sta = 1'b1;
    step(); sta = 1'b0;                 // REQ_UP
    step(); cmp_done = 1'b1; cmp_alb = 1'b1; // WAIT_UP, comparator answers
    step(); cmp_done = 1'b0; cmp_alb = 1'b0; // REQ_LO
    check("mid_sta_lo", 32'(cmp_sta), 32'd1);
    step();                             // WAIT_LO
    rst = 1'b1;
    step();
    check("mid_rst_lim", limit_out, 32'd0);
    check("mid_rst_in",  cmp_in_1 | cmp_in_2, 32'd0);
    check("mid_rst_sig", 32'({cmp_sta, hi_flag, lo_flag, done_sig, err}), 32'd0);
    rst = 1'b0; cmp_done = 1'b1; cmp_alb = 1'b1;
    step();
    cmp_done = 1'b0; cmp_alb = 1'b0;
    check("late_done", 32'(done_sig), 32'd0);
    step();
    check("late_done2", 32'(done_sig), 32'd0);
    check("late_lim",   limit_out, 32'd0);
    run_txn("after_rst", F_P1, F_P1, F_N1, 1'b0, 1'b0, 1'b1, 1'b0, F_P1, 1'b0, 1'b0, 5, 2);

    // Second sta during WAIT_UP is ignored.
    value = F_P5; upper = F_P3; lower = F_N3; sta = 1'b1;
    step(); sta = 1'b0;                 // REQ_UP
    step();                             // WAIT_UP, no answer yet
    value = F_N5; upper = F_P10; lower = F_P8; sta = 1'b1;
    step(); sta = 1'b0;                 // still WAIT_UP
    check("resta_in1", cmp_in_1, F_P5);
    check("resta_in2", cmp_in_2, F_P3);
    cmp_done = 1'b1; cmp_agb = 1'b1;
    step();                             // DONE
    cmp_done = 1'b0; cmp_agb = 1'b0;
    check("resta_done", 32'(done_sig), 32'd1);
    check("resta_lim",  limit_out, F_P3);
    check("resta_hi",   32'(hi_flag), 32'd1);
    step();
    check("resta_idle", 32'(cmp_sta), 32'd0);
    step();
    check("resta_idle2", 32'(cmp_sta), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
